// File: rtl/conv_stream_engine.sv
// Streaming stride-1 valid 2-D convolution over a raster pixel stream, NUM_FEATURES kernels.
// Optional ReLU after saturation when CONV_RELU_EN is defined.
module conv_stream_engine #(
    parameter int unsigned IMAGE_WIDTH  = 28,
    parameter int unsigned IMAGE_HEIGHT = 28,
    parameter int unsigned NUM_FEATURES = 10,
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned COEF_W       = 8,
    parameter int unsigned OUT_W        = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_cnn,
    input  logic                                          start,
    input  logic                                          weight_wr_en,
    input  logic [$clog2(NUM_FEATURES):0]                 weight_wr_addr,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*COEF_W-1:0]     weight_wr_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DATA_W-1:0]                             in_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_FEATURES*OUT_W-1:0]                 out_data,
    output logic                                          busy,
    output logic                                          frame_done
);
    localparam int unsigned K    = KERNEL_SIZE;
    localparam int unsigned KK   = K * K;
    localparam int unsigned PW   = DATA_W + COEF_W;
    localparam int unsigned AW   = PW + $clog2(KK);
    localparam int unsigned CW   = $clog2(IMAGE_WIDTH);
    localparam int unsigned RW   = $clog2(IMAGE_HEIGHT);
    localparam int unsigned NOUT = (IMAGE_HEIGHT - K + 1) * (IMAGE_WIDTH - K + 1);
    localparam int unsigned OCW  = $clog2(NOUT + 1);
    localparam int unsigned FAW  = $clog2(NUM_FEATURES) + 1;

    localparam logic [CW-1:0]  ColLast  = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0]  ColFirst = CW'(K - 1);
    localparam logic [RW-1:0]  RowLast  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0]  RowFirst = RW'(K - 1);
    localparam logic [OCW-1:0] OcLast   = OCW'(NOUT - 1);
    localparam logic [FAW-1:0] NumFeat  = FAW'(NUM_FEATURES);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;
    logic [RW-1:0]  row_q;
    logic [CW-1:0]  col_q;
    logic [OCW-1:0] out_cnt_q;
    logic [KK*COEF_W-1:0] weights_q [NUM_FEATURES];
    logic [DATA_W-1:0]    lb_q [K-1][IMAGE_WIDTH];
    logic signed [DATA_W-1:0] win_q [K][K];
    logic win_v_q, res_v_q, out_valid_q;
    logic [NUM_FEATURES*OUT_W-1:0] res_q, out_data_q, mac_res;
    logic start_frame, accept, adv, out_fire, last_pix;

    assign adv       = !(out_valid_q && !out_ready);
    assign in_ready  = (state_q == StRun) && adv;
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign last_pix  = (row_q == RowLast) && (col_q == ColLast);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        frame_done  = 1'b0;
        unique case (state_q)
            StIdle: if (start) begin
                state_d     = StRun;
                start_frame = 1'b1;
            end
            StRun: if (accept && last_pix) state_d = StDrain;
            StDrain: if (out_fire && out_cnt_q == OcLast) begin
                state_d    = StIdle;
                frame_done = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_frame) begin
                row_q     <= '0;
                col_q     <= '0;
                out_cnt_q <= '0;
            end else begin
                if (accept) begin
                    if (col_q == ColLast) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                if (out_fire) out_cnt_q <= out_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            for (int f = 0; f < NUM_FEATURES; f++) weights_q[f] <= '0;
        end else if (state_q == StIdle && weight_wr_en && weight_wr_addr < NumFeat) begin
            weights_q[weight_wr_addr] <= weight_wr_data;
        end
    end

    // Window shifts left; the new right column is the line-buffer column plus the incoming pixel.
    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            for (int j = 0; j < K - 1; j++)
                for (int c = 0; c < IMAGE_WIDTH; c++) lb_q[j][c] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win_q[i][j] <= '0;
            win_v_q <= 1'b0;
        end else if (start_frame) begin
            win_v_q <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
            for (int i = 0; i < K - 1; i++) win_q[i][K-1] <= lb_q[K-2-i][col_q];
            win_q[K-1][K-1] <= in_data;
            lb_q[0][col_q]  <= in_data;
            for (int j = 1; j < K - 1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
            win_v_q <= (row_q >= RowFirst) && (col_q >= ColFirst);
        end else if (adv) begin
            win_v_q <= 1'b0;
        end
    end

    logic signed [AW-1:0]  acc;
    logic signed [PW-1:0]  prod;
    logic [AW-OUT_W:0]     upper;
    logic [OUT_W-1:0]      sat;

    always_comb begin
        mac_res = '0;
        acc     = '0;
        prod    = '0;
        upper   = '0;
        sat     = '0;
        for (int f = 0; f < NUM_FEATURES; f++) begin
            acc = '0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    prod = $signed(win_q[i][j]) *
                           $signed(weights_q[f][(i*K+j)*COEF_W +: COEF_W]);
                    acc  = acc + {{(AW-PW){prod[PW-1]}}, prod};
                end
            end
            // Result fits when every bit above the output sign bit matches it.
            upper = acc[AW-1:OUT_W-1];
            if (upper == '0 || upper == '1) sat = acc[OUT_W-1:0];
            else if (acc[AW-1])             sat = {1'b1, {(OUT_W-1){1'b0}}};
            else                            sat = {1'b0, {(OUT_W-1){1'b1}}};
`ifdef CONV_RELU_EN
            if (sat[OUT_W-1]) sat = '0;
`endif
            mac_res[f*OUT_W +: OUT_W] = sat;
        end
    end

    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            res_v_q     <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            res_v_q     <= win_v_q;
            out_valid_q <= res_v_q;
            if (win_v_q) res_q      <= mac_res;
            if (res_v_q) out_data_q <= res_q;
        end
    end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed, table-driven bench for conv_stream_engine on a 5x5 image, K=3, two features.
module tb_conv_stream_engine;
    logic        clk = 1'b0;
    logic        rst_cnn = 1'b1;
    logic        start = 1'b0;
    logic        weight_wr_en = 1'b0;
    logic [1:0]  weight_wr_addr = '0;
    logic [71:0] weight_wr_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;
    logic        frame_done;

    conv_stream_engine #(
        .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .NUM_FEATURES(2), .KERNEL_SIZE(3),
        .DATA_W(8), .COEF_W(8), .OUT_W(16)
    ) dut (
        .clk(clk), .rst_cnn(rst_cnn), .start(start), .weight_wr_en(weight_wr_en),
        .weight_wr_addr(weight_wr_addr), .weight_wr_data(weight_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

`ifdef CONV_RELU_EN
    localparam int NegExp = 0;
`else
    localparam int NegExp = -9;
`endif

    typedef struct packed {
        logic        load;
        logic [71:0] w0;
        logic [71:0] w1;
        logic        ramp;
        logic [7:0]  pval;
        logic        stall;
        logic        midrun;
        int          e0;
        int          e1;
    } vec_t;

    vec_t vecs [7];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_cnt = 0;
    logic [31:0] got [$];
    int got_cyc [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_cnn && out_valid && out_ready) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int expv(input logic ramp, input int e, input int o);
        if (ramp) return e * ((o / 3 + 1) * 5 + (o % 3) + 1);
        return e;
    endfunction

    task automatic load_w(input logic [1:0] a, input logic [71:0] d);
        weight_wr_en = 1'b1; weight_wr_addr = a; weight_wr_data = d;
        @(posedge clk); #1;
        weight_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] d, output int acc_c);
        int g = 0;
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        acc_c = cyc;
        in_valid = 1'b0;
    endtask

    task automatic stall_seq(input int base);
        int g = 0;
        logic [31:0] snap;
        logic bad = 1'b0;
        while (got.size() < base + 2 && g < 200) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        snap = out_data;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data != snap || in_ready) bad = 1'b1;
        end
        check("stall_hold", bad, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    // Weight write and a stray start during RUN must both be ignored.
    task automatic midrun_seq();
        repeat (8) @(posedge clk);
        #1;
        weight_wr_en = 1'b1; weight_wr_addr = 2'd0; weight_wr_data = {9{8'h02}}; start = 1'b1;
        @(posedge clk); #1;
        weight_wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic run_frame(input int v);
        vec_t t;
        int base, fd0, a, acc_first, acc12, acc_last, g;
        t = vecs[v];
        acc_first = 0; acc12 = 0; acc_last = 0;
        if (t.load) begin
            load_w(2'd0, t.w0);
            load_w(2'd1, t.w1);
        end
        base = got.size();
        fd0 = fd_cnt;
        pulse_start();
        fork
            begin
                for (int p = 0; p < 25; p++) begin
                    send_pixel(t.ramp ? 8'(p) : t.pval, a);
                    if (p == 0)  acc_first = a;
                    if (p == 12) acc12 = a;
                    if (p == 24) acc_last = a;
                end
            end
            begin
                if (t.stall) stall_seq(base);
            end
            begin
                if (t.midrun) midrun_seq();
            end
        join
        g = 0;
        while (fd_cnt == fd0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (5) @(negedge clk);
        check($sformatf("row%0d_nout", v), got.size() - base, 9);
        for (int o = 0; o < 9; o++) begin
            if (base + o < got.size()) begin
                check($sformatf("row%0d_f0_%0d", v, o),
                      $signed(got[base+o][15:0]), expv(t.ramp, t.e0, o));
                check($sformatf("row%0d_f1_%0d", v, o),
                      $signed(got[base+o][31:16]), expv(t.ramp, t.e1, o));
            end
        end
        check($sformatf("row%0d_frame_done", v), fd_cnt - fd0, 1);
        check($sformatf("row%0d_busy_end", v), busy, 0);
        if (!t.stall) begin
            check($sformatf("row%0d_throughput", v), acc_last - acc_first, 24);
            if (got_cyc.size() > base)
                check($sformatf("row%0d_latency", v), got_cyc[base] - acc12, 2);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        int a;
        //             load  w0            w1                    ramp pval   stall mid e0      e1
        vecs[0] = '{1'b1, {9{8'h01}}, 72'h1 << 32,          1'b1, 8'd0,   1'b0, 1'b0, 9,      1};
        vecs[1] = '{1'b1, {9{8'h7f}}, {9{8'h7f}},           1'b0, 8'd127, 1'b0, 1'b0, 32767,  32767};
        vecs[2] = '{1'b1, {9{8'hff}}, {9{8'hff}},           1'b0, 8'd1,   1'b0, 1'b0, NegExp, NegExp};
        vecs[3] = '{1'b1, {9{8'h01}}, 72'h1 << 32,          1'b1, 8'd0,   1'b1, 1'b0, 9,      1};
        vecs[4] = '{1'b1, {9{8'h01}}, 72'h1 << 32,          1'b1, 8'd0,   1'b0, 1'b1, 9,      1};
        vecs[5] = '{1'b1, {9{8'h02}}, 72'h1 << 32,          1'b1, 8'd0,   1'b0, 1'b0, 18,     1};
        vecs[6] = '{1'b0, 72'h0,      72'h0,                1'b1, 8'd0,   1'b0, 1'b0, 0,      0};

        #2 rst_cnn = 1'b0;
        #1 check_reset_outputs("reset_asserted");
        repeat (2) @(posedge clk);
        #1 rst_cnn = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_released");
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) run_frame(v);

        // Mid-frame reset after 12 accepted pixels.
        load_w(2'd0, {9{8'h01}});
        load_w(2'd1, 72'h1 << 32);
        pulse_start();
        for (int p = 0; p < 12; p++) send_pixel(8'(p), a);
        rst_cnn = 1'b0;
        #1 check_reset_outputs("midframe_reset");
        @(posedge clk); #1;
        rst_cnn = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_midframe_reset");
        @(posedge clk); #1;

        run_frame(6);
        run_frame(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/conv_stream_engine.md
# conv_stream_engine

Streaming 2-D convolution engine that replaces the whole-image, array-input convolution stage with a raster-order pixel stream, on-chip line buffers and valid/ready handshakes on both sides. Per frame it computes stride-1 valid convolutions for NUM_FEATURES kernels in parallel, one output window per accepted pixel once the window is full. Outputs are saturated to a configurable width. Kernel weights are loaded through a write port between frames. The block sits between the image source and the downstream pooling/classifier logic.

## Interface
- IMAGE_WIDTH, 28, pixels per row (≥ KERNEL_SIZE)
- IMAGE_HEIGHT, 28, rows per frame (≥ KERNEL_SIZE)
- NUM_FEATURES, 10, parallel kernels/output channels
- KERNEL_SIZE, 3, square kernel edge (≥ 2)
- DATA_W, 8, signed pixel width
- COEF_W, 8, signed weight width
- OUT_W, 16, signed output width after saturation
- clk  in  1  sole clock; all state updates on posedge
- rst_cnn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame, honoured only in IDLE
- weight_wr_en  in  1  active-high weight write strobe, honoured only in IDLE
- weight_wr_addr  in  $clog2(NUM_FEATURES)+1  feature index; writes to indices ≥ NUM_FEATURES are ignored
- weight_wr_data  in  KERNEL_SIZE*KERNEL_SIZE*COEF_W  kernel, element 0 (top-left, raster order) in the LSBs
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  DATA_W  signed pixel
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  NUM_FEATURES*OUT_W  feature 0 in the LSBs
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse when the last output of a frame is accepted

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on start. Clears the row/column counters and the window valid flags.
  - RUN → DRAIN on acceptance of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
  - DRAIN → IDLE when the final output is accepted. frame_done pulses in that same cycle.
- A start pulse outside IDLE is ignored. A weight write outside IDLE is ignored, and weights stay stable during a frame.
- Line buffers hold KERNEL_SIZE-1 rows of DATA_W. The window register is KERNEL_SIZE×KERNEL_SIZE. Both shift only on pixel acceptance.
- The window at (r, c) is complete when the accepted pixel satisfies r ≥ K-1 and c ≥ K-1.
  - Result for output position (r-K+1, c-K+1) = Σ window[i]·weight[f][i].
  - Number of outputs per frame = (IMAGE_HEIGHT-K+1)·(IMAGE_WIDTH-K+1), emitted in raster order.
- Arithmetic:
  - Full-precision signed accumulator, width DATA_W+COEF_W+$clog2(K*K).
  - Result saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Windows never wrap across a row boundary. Pixels with c < K-1 or r < K-1 produce no output.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0, weights=0, line buffers=0, state=IDLE.
- Pipeline stages:
  - Stage 1: window capture, on the acceptance cycle.
  - Stage 2: MAC + saturation register.
  - Output register.
- Latency: out_valid rises 2 cycles after the acceptance edge of the window-completing pixel, with no backpressure.
- in_ready = (state==RUN) && !(out_valid && !out_ready). It is combinational from registered state and out_ready.
- Stall behaviour:
  - Under stall, every stage holds.
  - out_data stays stable while out_valid && !out_ready.
  - out_valid is not dropped without acceptance.
- Throughput: 1 pixel/cycle with out_ready held high.
- rst_cnn asserted mid-frame returns the block to IDLE immediately with the reset values listed above. Weights are also cleared.
- start in the same cycle as frame_done is ignored. It takes effect on the next cycle, once in IDLE.

## Configuration
- CONV_RELU_EN defined: ReLU is applied after saturation, so negative results output 0.
- CONV_RELU_EN undefined: signed saturated results pass through unchanged.

## Test plan
Common configuration: IMAGE 5×5, K=3, NUM_FEATURES=2, DATA_W=COEF_W=8, OUT_W=16.
- All-ones weights on feature 0, centre-only weight 1 on feature 1, ramp image pixel=r*5+c → 9 outputs. Feature 0 = 9·(centre value); feature 1 = centre value, e.g. first output = (54, 6). frame_done fires once.
- All pixels 127, all weights 127 → every feature output = 32767 (saturated from 145161).
- All pixels 1, all weights -1 → output 0 with CONV_RELU_EN, -9 without.
- out_ready held low for 10 cycles mid-frame → out_valid stays high, out_data unchanged, in_ready=0, all 9 outputs still delivered in order with no loss or duplication.
- weight_wr_en pulsed during RUN with new data → outputs use the old weights; a write in IDLE before the next start takes effect.
- rst_cnn pulsed after 12 accepted pixels → outputs return to reset values and busy=0. A subsequent reload and start produces a correct full frame.
